// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: per-hart msip/mtimecmp registers and a shared 64-bit mtime.
// Optional mtime prescaler enabled by defining CLINT_MH_PRESCALER_EN (TICK_DIV clk cycles per tick).
module clint_mh #(
    parameter int HART_NUM       = 2,
    parameter int TICK_DIV       = 1,
    parameter int ADDR_WIDTH     = 16,
    parameter int SIZE_WIDTH     = 4,
    parameter int REG_DATA_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
    input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
    input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
    input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
    input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
    input  logic                      bus_clint_rd,
    input  logic                      bus_clint_wr,
    output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
    output logic [HART_NUM-1:0]       all_intif_int_software_req,
    output logic [HART_NUM-1:0]       all_intif_int_timer_req
);

    localparam logic [ADDR_WIDTH-1:0] MSIP_END = ADDR_WIDTH'(4 * HART_NUM);
    localparam logic [ADDR_WIDTH-1:0] CMP_BASE = ADDR_WIDTH'(32'h0000_4000);
    localparam logic [ADDR_WIDTH-1:0] CMP_END  = ADDR_WIDTH'(32'h0000_4000 + 8 * HART_NUM);
    localparam logic [ADDR_WIDTH-1:0] MTIME_LO = ADDR_WIDTH'(32'h0000_BFF8);
    localparam logic [ADDR_WIDTH-1:0] MTIME_HI = ADDR_WIDTH'(32'h0000_BFFC);

    if (HART_NUM < 1 || HART_NUM > 64 || TICK_DIV < 1 || TICK_DIV > 65535 ||
        REG_DATA_WIDTH != 32 || ADDR_WIDTH < 16 || BUS_DATA_WIDTH < 32) begin : g_bad_param
        $error("clint_mh: illegal parameter value");
    end

    typedef struct packed {
        logic       msip;
        logic       cmp;
        logic       mt;
        logic [5:0] idx;
        logic       half;
    } dec_t;

    // half selects the high word of a 64-bit register; idx is the hart number
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] a);
        dec_t                  d;
        logic [ADDR_WIDTH-1:0] off;
        off    = a - CMP_BASE;
        d.msip = (a[1:0] == 2'b00) && (a < MSIP_END);
        d.cmp  = (a[1:0] == 2'b00) && (a >= CMP_BASE) && (a < CMP_END);
        d.mt   = (a == MTIME_LO) || (a == MTIME_HI);
        d.idx  = d.cmp ? 6'(off >> 3'd3) : 6'(a >> 3'd2);
        d.half = d.cmp ? off[2] : a[2];
        return d;
    endfunction

    logic [HART_NUM-1:0] r_msip;
    logic [63:0]         r_mtimecmp [HART_NUM];
    logic [63:0]         r_mtime;
    logic [31:0]         r_rdata;

    logic                w_rd_ok;
    logic                w_wr_ok;
    dec_t                w_rd_dec;
    dec_t                w_wr_dec;
    logic                w_tick;
    logic                w_mt_wr;
    logic [63:0]         w_mtime_inc;
    logic [63:0]         w_mtime_nxt;
    logic [HART_NUM-1:0] w_msip_nxt;
    logic [63:0]         w_cmp_nxt [HART_NUM];
    logic [31:0]         w_rdata;

    assign w_rd_ok  = bus_clint_rd && (bus_clint_read_size == SIZE_WIDTH'(3'd4));
    assign w_wr_ok  = bus_clint_wr && (bus_clint_write_size == SIZE_WIDTH'(3'd4));
    assign w_rd_dec = decode(bus_clint_read_addr);
    assign w_wr_dec = decode(bus_clint_write_addr);
    assign w_mt_wr  = w_wr_ok && w_wr_dec.mt;

`ifdef CLINT_MH_PRESCALER_EN
    logic [15:0] r_pre_cnt;

    assign w_tick = (r_pre_cnt == 16'(TICK_DIV - 1));

    // prescaler counter: 0..TICK_DIV-1, restarted by any mtime write
    always_ff @(posedge clk) begin
        if (rst || w_mt_wr || w_tick) begin
            r_pre_cnt <= 16'd0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 16'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // post-update state; the written mtime half takes bus data, the other half its ticked value
    always_comb begin
        w_mtime_inc = r_mtime + {63'd0, w_tick};
        w_mtime_nxt = !w_mt_wr ? w_mtime_inc :
                      (w_wr_dec.half ? {bus_clint_data, w_mtime_inc[31:0]}
                                     : {w_mtime_inc[63:32], bus_clint_data});
        for (int h = 0; h < HART_NUM; h++) begin
            w_msip_nxt[h] = (w_wr_ok && w_wr_dec.msip && w_wr_dec.idx == 6'(h)) ?
                            bus_clint_data[0] : r_msip[h];
            w_cmp_nxt[h]  = !(w_wr_ok && w_wr_dec.cmp && w_wr_dec.idx == 6'(h)) ? r_mtimecmp[h] :
                            (w_wr_dec.half ? {bus_clint_data, r_mtimecmp[h][31:0]}
                                           : {r_mtimecmp[h][63:32], bus_clint_data});
        end
    end

    // read mux over post-update values so a same-cycle write is visible
    always_comb begin
        w_rdata = 32'h0;
        if (w_rd_dec.mt) begin
            w_rdata = w_rd_dec.half ? w_mtime_nxt[63:32] : w_mtime_nxt[31:0];
        end else begin
            for (int h = 0; h < HART_NUM; h++) begin
                w_rdata = w_rdata |
                    ((w_rd_dec.cmp && w_rd_dec.idx == 6'(h)) ?
                        (w_rd_dec.half ? w_cmp_nxt[h][63:32] : w_cmp_nxt[h][31:0]) : 32'h0) |
                    ((w_rd_dec.msip && w_rd_dec.idx == 6'(h)) ? {31'd0, w_msip_nxt[h]} : 32'h0);
            end
        end
    end

    // architectural state and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_msip     <= '0;
            r_mtime    <= 64'd0;
            r_mtimecmp <= '{default: 64'hFFFF_FFFF_FFFF_FFFF};
            r_rdata    <= 32'h0;
        end else begin
            r_msip     <= w_msip_nxt;
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            if (w_rd_ok) begin
                r_rdata <= w_rdata;
            end
        end
    end

    always_comb begin
        for (int h = 0; h < HART_NUM; h++) begin
            all_intif_int_timer_req[h] = (r_mtime >= r_mtimecmp[h]);
        end
    end

    assign all_intif_int_software_req = r_msip;
    assign clint_bus_data             = BUS_DATA_WIDTH'(r_rdata);

endmodule

// File: doc/clint_mh.md
CLINT_MH -- requirements
Module: clint_mh

Interface
REQ-001 SHALL have parameter HART_NUM, default 2: number of harts, legal range 1..64.
REQ-002 SHALL have parameter TICK_DIV, default 1: clk cycles per mtime increment, legal range 1..65535, used only when CLINT_MH_PRESCALER_EN is defined.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bus_clint_read_addr  input  ADDR_WIDTH  read byte offset.
REQ-006 SHALL have port bus_clint_write_addr  input  ADDR_WIDTH  write byte offset.
REQ-007 SHALL have port bus_clint_read_size  input  SIZE_WIDTH  read size in bytes.
REQ-008 SHALL have port bus_clint_write_size  input  SIZE_WIDTH  write size in bytes.
REQ-009 SHALL have port bus_clint_data  input  REG_DATA_WIDTH (32)  write data.
REQ-010 SHALL have port bus_clint_rd  input  1  read strobe.
REQ-011 SHALL have port bus_clint_wr  input  1  write strobe.
REQ-012 SHALL have port clint_bus_data  output  BUS_DATA_WIDTH  registered read data.
REQ-013 SHALL have port all_intif_int_software_req  output  HART_NUM  per-hart MSIP, bit h = hart h.
REQ-014 SHALL have port all_intif_int_timer_req  output  HART_NUM  per-hart MTIP, bit h = hart h.

Function
REQ-015 SHALL decode this map, 32-bit words: msip[h] at 0x0000+4h; mtimecmp[h] low word at 0x4000+8h, high word at 0x4004+8h; mtime low word at 0xBFF8, high word at 0xBFFC; h < HART_NUM.
REQ-016 SHALL act only on accesses with size == 4; an access of any other size, or to an unmapped or h >= HART_NUM address, SHALL change no state.
REQ-017 SHALL store only bus_clint_data[0] on an msip write; msip[h] reads back zero-extended.
REQ-018 SHALL replace only the addressed 32-bit half on a mtimecmp write; the other half SHALL be kept.
REQ-019 SHALL keep a 64-bit mtime that increments by 1 on every tick cycle and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-020 SHALL, on a mtime half write, load the written half from bus data; the other half SHALL take its post-tick value (mtime+1 if tick, else mtime); no carry from the written half.
REQ-021 SHALL register read data one cycle after bus_clint_rd and size == 4; the value SHALL be the post-update value of that cycle, so a same-cycle write to the same address returns the new data.
REQ-022 SHALL drive clint_bus_data to 0 for a valid-size read of an unmapped address; it SHALL hold its value when no valid read occurs.
REQ-023 SHALL set all_intif_int_timer_req[h] = (mtime >= mtimecmp[h]), unsigned 64-bit, combinational from registered state.
REQ-024 SHALL set all_intif_int_software_req[h] = msip[h] combinationally from the register.

Reset
REQ-025 SHALL, on rst, clear msip[*], mtime, the prescaler counter and clint_bus_data to 0.
REQ-026 SHALL, on rst, set every mtimecmp[h] to 0xFFFF_FFFF_FFFF_FFFF, so no timer request is asserted after reset.
REQ-027 SHALL give rst priority over any same-cycle read or write; the access is discarded.

Configuration
REQ-028 SHALL, with CLINT_MH_PRESCALER_EN defined, generate a tick when a counter counting 0..TICK_DIV-1 wraps to 0; any mtime write SHALL clear the counter.
REQ-029 SHALL, with CLINT_MH_PRESCALER_EN undefined, treat every non-reset cycle as a tick, ignore TICK_DIV, and contain no counter.

Verification
REQ-030 SHALL cover this case: reset, read 0x4008 and 0x400C -> 0xFFFFFFFF both; timer_req = 2'b00; software_req = 2'b00.
REQ-031 SHALL cover this case: write 0x0004 data 0x3 -> software_req = 2'b10; read 0x0004 -> 0x1; write 0x0004 size 2 data 0 -> unchanged.
REQ-032 SHALL cover this case: prescaler on, TICK_DIV=4, write 0xBFF8=0xFFFFFFFE and 0xBFFC=0 -> mtime reaches 0x1_00000000 after 8 cycles; read 0xBFFC -> 0x1.
REQ-033 SHALL cover this case: write mtimecmp[0] = 0x10 (lo), 0 (hi), mtime = 0 -> timer_req[0] rises on the cycle mtime == 0x10; timer_req[1] stays 0.
REQ-034 SHALL cover this case: write 0x0008 (h=2, HART_NUM=2) data 1 -> no state change; read 0x0008 -> 0x0.
REQ-035 SHALL cover this case: assert rst during a write to 0x4000 -> mtimecmp[0] = all-ones afterwards.
